// File: rtl/mpu2_intc.sv
// rtl/mpu2_intc.sv - 8-source interrupt controller for the mpu2 core I/O bus
// Optional software trigger register at offset 5 enabled by MPU2_INTC_SWTRIG_EN.
module mpu2_intc #(
  parameter int          NSRC      = 8,
  parameter logic [7:0]  BASE_ADDR = 8'hF0
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [NSRC-1:0] src,
  input  logic [7:0]      port_id,
  input  logic            write_strobe,
  input  logic            read_strobe,
  input  logic [7:0]      wr_data,
  output logic [7:0]      rd_data,
  output logic            rd_sel,
  output logic            interrupt
);

  logic [NSRC-1:0] s1, s2, prev;
  logic [NSRC-1:0] pending, mask, edge_mode;
  logic [NSRC-1:0] pend_nxt, rise, clr, active;
  logic [2:0]      off;
  logic [2:0]      idx;
  logic            valid;
  logic            wr_mask, wr_clear, wr_edge;
  logic [7:0]      pend8, mask8, edge8;
  logic            unused_rd;

  assign unused_rd = read_strobe;
  assign rd_sel    = (port_id[7:3] == BASE_ADDR[7:3]);
  assign off       = port_id[2:0];
  assign wr_mask   = write_strobe && rd_sel && (off == 3'd1);
  assign wr_clear  = write_strobe && rd_sel && (off == 3'd2);
  assign wr_edge   = write_strobe && rd_sel && (off == 3'd4);
  assign active    = pending & mask;
  assign valid     = |active;

  // A new rising edge (hardware or software) wins over a simultaneous clear.
  always_comb begin
    rise = s2 & ~prev;
`ifdef MPU2_INTC_SWTRIG_EN
    if (write_strobe && rd_sel && (off == 3'd5))
      rise = rise | wr_data[NSRC-1:0];
`endif
    clr      = wr_clear ? wr_data[NSRC-1:0] : '0;
    pend_nxt = (edge_mode & (rise | (pending & ~clr))) | (~edge_mode & s2);
  end

  always_comb begin
    idx = 3'd0;
    for (int k = NSRC - 1; k >= 0; k--)
      if (active[k]) idx = 3'(k);
  end

  always_comb begin
    pend8 = '0;
    mask8 = '0;
    edge8 = '0;
    pend8[NSRC-1:0] = pending;
    mask8[NSRC-1:0] = mask;
    edge8[NSRC-1:0] = edge_mode;
    rd_data = 8'h00;
    if (rd_sel) begin
      case (off)
        3'd0:    rd_data = pend8;
        3'd1:    rd_data = mask8;
        3'd3:    rd_data = {valid, 4'b0000, idx};
        3'd4:    rd_data = edge8;
        default: rd_data = 8'h00;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1        <= '0;
      s2        <= '0;
      prev      <= '0;
      pending   <= '0;
      mask      <= '0;
      edge_mode <= '1;
      interrupt <= 1'b0;
    end else begin
      s1        <= src;
      s2        <= s1;
      prev      <= s2;
      pending   <= pend_nxt;
      interrupt <= |active;
      if (wr_mask) mask      <= wr_data[NSRC-1:0];
      if (wr_edge) edge_mode <= wr_data[NSRC-1:0];
    end
  end

endmodule

// File: tb/tb_mpu2_intc.sv
// tb/tb_mpu2_intc.sv - directed and randomized checks of mpu2_intc against a sample-history model
// Honours MPU2_INTC_SWTRIG_EN the same way as the design.
module tb_mpu2_intc;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] src = '0;
  logic [7:0] port_id = 8'h00;
  logic       write_strobe = 1'b0;
  logic       read_strobe = 1'b0;
  logic [7:0] wr_data = '0;
  logic [7:0] rd_data;
  logic       rd_sel;
  logic       interrupt;

  int vectors = 0;
  int errors  = 0;

  // Reference: src samples taken at the last three edges, plus architectural registers.
  logic [7:0] h0, h1, h2;
  logic [7:0] m_pend, m_mask, m_edge;
  logic       m_int;

  mpu2_intc #(.NSRC(8), .BASE_ADDR(8'hF0)) dut (
    .clk(clk), .rst_n(rst_n), .src(src), .port_id(port_id),
    .write_strobe(write_strobe), .read_strobe(read_strobe), .wr_data(wr_data),
    .rd_data(rd_data), .rd_sel(rd_sel), .interrupt(interrupt)
  );

  always #10 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%02h expected=%02h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] m_vector();
    logic [7:0] a;
    a = m_pend & m_mask;
    for (int k = 0; k < 8; k++)
      if (a[k]) return 8'h80 | 8'(k);
    return 8'h00;
  endfunction

  task automatic model_reset();
    h0 = '0; h1 = '0; h2 = '0;
    m_pend = '0; m_mask = '0; m_edge = 8'hFF; m_int = 1'b0;
  endtask

  // Applies the current inputs at the next rising edge, in DUT and model.
  task automatic tick();
    logic       wr;
    logic [7:0] rise, clr, np;
    wr   = write_strobe && (port_id[7:3] == 5'h1E);
    rise = h1 & ~h2;
`ifdef MPU2_INTC_SWTRIG_EN
    if (wr && port_id[2:0] == 3'd5) rise = rise | wr_data;
`endif
    clr = (wr && port_id[2:0] == 3'd2) ? wr_data : 8'h00;
    for (int k = 0; k < 8; k++)
      np[k] = m_edge[k] ? (rise[k] ? 1'b1 : (clr[k] ? 1'b0 : m_pend[k])) : h1[k];
    m_int = |(m_pend & m_mask);
    if (wr && port_id[2:0] == 3'd1) m_mask = wr_data;
    if (wr && port_id[2:0] == 3'd4) m_edge = wr_data;
    m_pend = np;
    h2 = h1; h1 = h0; h0 = src;
    @(posedge clk);
    #1;
    write_strobe = 1'b0;
    wr_data = '0;
  endtask

  task automatic wr_reg(input logic [2:0] off, input logic [7:0] d);
    port_id = 8'hF0 | 8'(off);
    wr_data = d;
    write_strobe = 1'b1;
    tick();
  endtask

  task automatic rd_reg(input logic [2:0] off, output logic [7:0] d);
    port_id = 8'hF0 | 8'(off);
    read_strobe = 1'b1;
    #1;
    d = rd_data;
    read_strobe = 1'b0;
  endtask

  task automatic check_model(input string tag);
    logic [7:0] d;
    chk({tag, ".int"}, {7'b0, interrupt}, {7'b0, m_int});
    rd_reg(3'd0, d); chk({tag, ".pend"}, d, m_pend);
    rd_reg(3'd1, d); chk({tag, ".mask"}, d, m_mask);
    rd_reg(3'd3, d); chk({tag, ".vec"},  d, m_vector());
    rd_reg(3'd4, d); chk({tag, ".edge"}, d, m_edge);
  endtask

  initial begin
    logic [7:0] d;
    logic [7:0] pid;
    model_reset();
    #25;
    rst_n = 1'b1;
    @(posedge clk); #1;

    // 1: reset values, decode window
    rd_reg(3'd0, d); chk("rst.pend", d, 8'h00);
    rd_reg(3'd1, d); chk("rst.mask", d, 8'h00);
    rd_reg(3'd2, d); chk("rst.clear", d, 8'h00);
    rd_reg(3'd3, d); chk("rst.vec", d, 8'h00);
    rd_reg(3'd4, d); chk("rst.edge", d, 8'hFF);
    chk("rst.int", {7'b0, interrupt}, 8'h00);
    for (int i = 0; i < 8; i++) begin
      pid = (i < 4) ? 8'hEC + 8'(i) : 8'hF8 + 8'(i - 4);
      port_id = 8'hF0 + 8'(i); #1;
      chk("rd_sel.in", {7'b0, rd_sel}, 8'h01);
      port_id = pid; #1;
      chk("rd_sel.out", {7'b0, rd_sel}, 8'h00);
      chk("rd_data.unsel", rd_data, 8'h00);
    end

    // 2: edge latency and clear timing
    wr_reg(3'd1, 8'h05);
    src = 8'h04;
    tick(); tick();
    rd_reg(3'd0, d); chk("t2.pend_early", d, 8'h00);
    tick(); src = 8'h00;
    rd_reg(3'd0, d); chk("t2.pend", d, 8'h04);
    chk("t2.int_early", {7'b0, interrupt}, 8'h00);
    tick();
    chk("t2.int", {7'b0, interrupt}, 8'h01);
    rd_reg(3'd3, d); chk("t2.vec", d, 8'h82);
    wr_reg(3'd2, 8'h04);
    rd_reg(3'd0, d); chk("t2.pend_clr", d, 8'h00);
    chk("t2.int_hold", {7'b0, interrupt}, 8'h01);
    tick();
    chk("t2.int_low", {7'b0, interrupt}, 8'h00);
    check_model("t2");

    // 3: priority
    wr_reg(3'd1, 8'hFF);
    src = 8'h28;
    tick(); tick(); tick(); tick();
    rd_reg(3'd3, d); chk("t3.vec83", d, 8'h83);
    wr_reg(3'd2, 8'h08);
    rd_reg(3'd3, d); chk("t3.vec85", d, 8'h85);
    wr_reg(3'd2, 8'h20);
    tick();
    rd_reg(3'd3, d); chk("t3.vec00", d, 8'h00);
    chk("t3.int", {7'b0, interrupt}, 8'h00);
    src = 8'h00;
    tick(); tick(); tick();
    check_model("t3");

    // 4: level source ignores clear, follows the line
    wr_reg(3'd4, 8'hFE);
    wr_reg(3'd1, 8'h01);
    src = 8'h01;
    tick(); tick(); tick(); tick();
    chk("t4.int", {7'b0, interrupt}, 8'h01);
    wr_reg(3'd2, 8'h01);
    tick();
    rd_reg(3'd0, d); chk("t4.pend_kept", d, 8'h01);
    chk("t4.int_kept", {7'b0, interrupt}, 8'h01);
    src = 8'h00;
    tick(); tick();
    rd_reg(3'd0, d); chk("t4.pend_2", d, 8'h01);
    tick();
    rd_reg(3'd0, d); chk("t4.pend_3", d, 8'h00);
    chk("t4.int_3", {7'b0, interrupt}, 8'h01);
    tick();
    chk("t4.int_4", {7'b0, interrupt}, 8'h00);

    // 5: set beats clear, async reset
    wr_reg(3'd4, 8'hFF);
    wr_reg(3'd1, 8'hFF);
    src = 8'h02;
    tick(); tick();
    wr_reg(3'd2, 8'h02);
    rd_reg(3'd0, d); chk("t5.set_wins", d, 8'h02);
    tick();
    chk("t5.int", {7'b0, interrupt}, 8'h01);
    #3 rst_n = 1'b0;
    #1 chk("t5.int_async", {7'b0, interrupt}, 8'h00);
    model_reset();
    src = 8'h00;
    @(posedge clk); #2;
    rst_n = 1'b1;
    @(posedge clk); #1;
    check_model("t5.post");

    // 6: software trigger
    wr_reg(3'd5, 8'h40);
    wr_reg(3'd1, 8'h40);
    tick();
    rd_reg(3'd5, d); chk("t6.swtrig_rd", d, 8'h00);
`ifdef MPU2_INTC_SWTRIG_EN
    chk("t6.int", {7'b0, interrupt}, 8'h01);
    rd_reg(3'd3, d); chk("t6.vec", d, 8'h86);
`else
    rd_reg(3'd0, d); chk("t6.pend", d, 8'h00);
    chk("t6.int", {7'b0, interrupt}, 8'h00);
`endif
    check_model("t6");

    // randomized traffic against the model
    for (int n = 0; n < 400; n++) begin
      if ($urandom_range(0, 2) == 0) src = src ^ 8'($urandom_range(0, 255));
      if ($urandom_range(0, 3) == 0) begin
        port_id = ($urandom_range(0, 7) == 0) ? 8'($urandom_range(0, 255)) : 8'hF0 | 8'($urandom_range(0, 7));
        wr_data = 8'($urandom_range(0, 255));
        write_strobe = 1'b1;
      end
      tick();
      check_model("rnd");
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
